// File: rtl/sc_fifo_pkg.sv
// Shared sizing helpers and reset values for the single-clock FIFO.
// Pointer wrap is explicit so any DEPTH works, not only powers of two.
package sc_fifo_pkg;

    localparam logic RST_EMPTY = 1'b1;
    localparam logic RST_FULL  = 1'b0;
    localparam logic RST_PULSE = 1'b0;

    function automatic int f_nb_count(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int f_ptr_next(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sc_fifo_ptr.sv
// Wrap-around pointer 0..DEPTH-1, advances by one when enabled.
// Single cycle update, synchronous active-high reset to zero.
module sc_fifo_ptr
    import sc_fifo_pkg::*;
#(
    parameter  int DEPTH  = 8,
    localparam int NB_PTR = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_en,
    output logic [NB_PTR-1:0] o_ptr
);

    always_ff @(posedge i_clock) begin
        if (i_reset)
            o_ptr <= '0;
        else if (i_en)
            o_ptr <= NB_PTR'(f_ptr_next(int'(o_ptr), DEPTH));
    end

endmodule

// File: rtl/sc_fifo.sv
// Single-clock FIFO with count, almost flags and overflow/underflow pulses; rejects (never stalls) bad requests.
// Read latency 1 by default; define SC_FIFO_FWFT_EN for first-word-fall-through output.
module sc_fifo
    import sc_fifo_pkg::*;
#(
    parameter  int NB_DATA   = 4,
    parameter  int DEPTH     = 8,
    parameter  int AF_THRESH = 6,
    parameter  int AE_THRESH = 1,
    localparam int NB_COUNT  = f_nb_count(DEPTH)
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_wr_en,
    input  logic [NB_DATA-1:0]  i_data,
    input  logic                i_rd_en,
    output logic [NB_DATA-1:0]  o_data,
    output logic                o_rd_valid,
    output logic                o_full,
    output logic                o_empty,
    output logic                o_almost_full,
    output logic                o_almost_empty,
    output logic [NB_COUNT-1:0] o_count,
    output logic                o_overflow,
    output logic                o_underflow
);

    localparam int NB_PTR = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [NB_COUNT-1:0] FULL_CNT = NB_COUNT'(DEPTH);
    localparam logic [NB_COUNT-1:0] AF_CNT   = NB_COUNT'(AF_THRESH);
    localparam logic [NB_COUNT-1:0] AE_CNT   = NB_COUNT'(AE_THRESH);

    logic [NB_DATA-1:0]  mem [DEPTH];
    logic [NB_PTR-1:0]   wptr;
    logic [NB_PTR-1:0]   rptr;
    logic [NB_COUNT-1:0] count_q;
    logic                wr_acc;
    logic                rd_acc;

    // Acceptance uses start-of-cycle flags only: no bypass between read and write.
    assign wr_acc = i_wr_en && !o_full  && !i_reset;
    assign rd_acc = i_rd_en && !o_empty && !i_reset;

    assign o_count        = count_q;
    assign o_full         = (count_q == FULL_CNT);
    assign o_empty        = (count_q == '0);
    assign o_almost_full  = (count_q >= AF_CNT);
    assign o_almost_empty = (count_q <= AE_CNT);

    sc_fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_en    (wr_acc),
        .o_ptr   (wptr)
    );

    sc_fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_en    (rd_acc),
        .o_ptr   (rptr)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count_q     <= '0;
            o_overflow  <= RST_PULSE;
            o_underflow <= RST_PULSE;
        end else begin
            o_overflow  <= i_wr_en && o_full;
            o_underflow <= i_rd_en && o_empty;
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge i_clock) begin
        if (wr_acc)
            mem[wptr] <= i_data;
    end

`ifdef SC_FIFO_FWFT_EN
    assign o_data     = o_empty ? '0 : mem[rptr];
    assign o_rd_valid = 1'b0;
`else
    logic [NB_DATA-1:0] data_q;
    logic               rd_valid_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            data_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc)
                data_q <= mem[rptr];
        end
    end

    assign o_data     = data_q;
    assign o_rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sc_fifo.sv
// Self-checking bench for sc_fifo (4-bit, depth 8, AF 6, AE 1); builds with or without SC_FIFO_FWFT_EN.
module tb_sc_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [3:0] din = '0;
    logic [3:0] dout;
    logic       rd_valid, full, empty, afull, aempty, ovf, unf;
    logic [3:0] count;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    sc_fifo #(.NB_DATA(4), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_wr_en        (wr_en),
        .i_data         (din),
        .i_rd_en        (rd_en),
        .o_data         (dout),
        .o_rd_valid     (rd_valid),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (afull),
        .o_almost_empty (aempty),
        .o_count        (count),
        .o_overflow     (ovf),
        .o_underflow    (unf)
    );

    // Reference model: a queue of stored words plus the registered side outputs.
    logic [3:0] q[$];
    bit         m_ovf, m_unf, m_rv;
    logic [3:0] m_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit w, input logic [3:0] d, input bit rd);
        bit was_full, was_empty;
        if (r) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_rv = 0; m_data = '0;
        end else begin
            was_full  = (q.size() == 8);
            was_empty = (q.size() == 0);
            m_ovf = w && was_full;
            m_unf = rd && was_empty;
            m_rv  = rd && !was_empty;
            if (rd && !was_empty) m_data = q.pop_front();
            if (w && !was_full) q.push_back(d);
        end
    endtask

    task automatic check_outputs();
        chk("count",  count,  q.size());
        chk("full",   full,   q.size() == 8);
        chk("empty",  empty,  q.size() == 0);
        chk("afull",  afull,  q.size() >= 6);
        chk("aempty", aempty, q.size() <= 1);
        chk("ovf",    ovf,    m_ovf);
        chk("unf",    unf,    m_unf);
`ifdef SC_FIFO_FWFT_EN
        chk("rd_valid", rd_valid, 0);
        if (q.size() > 0) chk("head", dout, q[0]);
`else
        chk("rd_valid", rd_valid, m_rv);
        chk("data",     dout,     m_data);
`endif
    endtask

    task automatic cyc(input bit r, input bit w, input logic [3:0] d, input bit rd);
        rst = r; wr_en = w; din = d; rd_en = rd;
        @(posedge clk);
        #1;
        model_step(r, w, d, rd);
        check_outputs();
    endtask

    typedef struct {
        bit         rst;
        bit         wr;
        logic [3:0] d;
        bit         rd;
        int         cnt;
        bit         ovf;
        bit         unf;
    } vec_t;

    function automatic vec_t mk(bit r, bit w, logic [3:0] d, bit rd, int c, bit o, bit u);
        vec_t v;
        v.rst = r; v.wr = w; v.d = d; v.rd = rd; v.cnt = c; v.ovf = o; v.unf = u;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        m_ovf = 0; m_unf = 0; m_rv = 0; m_data = '0;

        // Reset/idle, fill 1..8, overflow with 0xF, drain, underflow.
        tbl.push_back(mk(1, 0, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, 0, 0));
        for (int k = 1; k <= 8; k++) tbl.push_back(mk(0, 1, 4'(k), 0, k, 0, 0));
        tbl.push_back(mk(0, 1, 4'hF, 0, 8, 1, 0));
        for (int k = 7; k >= 0; k--) tbl.push_back(mk(0, 0, 4'h0, 1, k, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].wr, tbl[i].d, tbl[i].rd);
            chk("tbl_count", count, tbl[i].cnt);
            chk("tbl_ovf",   ovf,   tbl[i].ovf);
            chk("tbl_unf",   unf,   tbl[i].unf);
            if (i == 1) chk("reset_data", dout, 0);
        end

        // Steady state at depth 3 with simultaneous read/write; pointers wrap twice.
        cyc(1, 0, 4'h0, 0);
        for (int k = 1; k <= 3; k++) cyc(0, 1, 4'(k), 0);
        for (int k = 0; k < 20; k++) begin
            cyc(0, 1, 4'(k + 4), 1);
            chk("t4_count", count, 3);
        end

        // Full with write and read together: read wins, write rejected.
        cyc(1, 0, 4'h0, 0);
        for (int k = 0; k < 8; k++) cyc(0, 1, 4'(k + 8), 0);
        cyc(0, 1, 4'hF, 1);
        chk("t5_count", count, 7);
        chk("t5_ovf",   ovf,   1);

        // Mid-stream reset discards contents and ignores same-cycle requests.
        cyc(1, 0, 4'h0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 1, 4'(k + 3), 0);
        cyc(1, 1, 4'h5, 1);
        chk("t6_count", count, 0);
        chk("t6_empty", empty, 1);
        cyc(0, 1, 4'hA, 0);
`ifdef SC_FIFO_FWFT_EN
        chk("t6_head", dout, 4'hA);
`endif
        cyc(0, 0, 4'h0, 1);
`ifndef SC_FIFO_FWFT_EN
        chk("t6_data",  dout,     4'hA);
        chk("t6_valid", rd_valid, 1);
`endif
        chk("t6_count_after", count, 0);

        // Random traffic against the model, with occasional resets.
        for (int k = 0; k < 600; k++) begin
            cyc($urandom_range(0, 63) == 0,
                $urandom_range(0, 99) < 55,
                4'($urandom),
                $urandom_range(0, 99) < 50);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
